// File: rtl/icache_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch cache: block geometry,
// fill-controller state codes and address-field width helpers.
package icache_fetch_unit_pkg;

    localparam int ADDR_BITS       = 16;
    localparam int BLOCK_BYTES     = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_BITS     = 4;

    typedef logic [1:0] fill_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILL    = 2'd1;
    localparam logic [1:0] ST_INSTALL = 2'd2;

    function automatic int offset_width();
        return $clog2(BLOCK_BYTES);
    endfunction

    function automatic int index_width(input int index_bits);
        return index_bits;
    endfunction

    function automatic int tag_width(input int index_bits);
        return ADDR_BITS - OFFSET_BITS - index_bits;
    endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Miss-handling FSM: issues eight word reads for one block as grants arrive
// and steers returning words into the line being filled.
module icache_fill_ctrl
    import icache_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] start_block,
    input  logic        mem_grant,
    input  logic        mem_data_valid,
    output fill_state_t state,
    output logic [11:0] block,
    output logic [2:0]  rc,
    output logic        data_we,
    output logic        install,
    output logic        mem_en,
    output logic [15:0] mem_addr
);

    // ic counts issued requests 0..8; bit 3 set means all eight are out.
    logic [3:0] ic;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            block <= '0;
            ic    <= '0;
            rc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FILL;
                        block <= start_block;
                        ic    <= '0;
                        rc    <= '0;
                    end
                end
                ST_FILL: begin
                    if (mem_en && mem_grant)
                        ic <= ic + 4'd1;
                    if (mem_data_valid) begin
                        rc <= rc + 3'd1;
                        if (rc == 3'd7)
                            state <= ST_INSTALL;
                    end
                end
                ST_INSTALL: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Word addresses wrap inside the block: no carry out of the offset field.
    assign mem_en   = !rst && (state == ST_FILL) && !ic[3];
    assign mem_addr = mem_en ? {block, ic[2:0], 1'b0} : 16'h0000;
    assign data_we  = (state == ST_FILL) && mem_data_valid;
    assign install  = (state == ST_INSTALL);

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache for the fetch stage; hits return in the same cycle.
// Optional hit/miss perf counters are built only when ICACHE_PERF_EN is defined.
module icache_fetch_unit
    import icache_fetch_unit_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    localparam int TAG_BITS  = tag_width(INDEX_BITS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_addr,
    input  logic        flush,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic        icache_stall,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    input  logic        mem_grant,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_BITS-1:0]   tags [NUM_BLOCKS];
    logic [15:0]           data [NUM_BLOCKS][WORDS_PER_BLOCK];

    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] pc_index;
    logic [2:0]            pc_word;
    logic                  unused_pc_bit0;

    fill_state_t           state;
    logic [11:0]           block;
    logic [2:0]            rc;
    logic                  data_we;
    logic                  install;
    logic                  lookup_hit;
    logic                  start;

    assign pc_tag         = pc_addr[15:4+INDEX_BITS];
    assign pc_index       = pc_addr[3+INDEX_BITS:4];
    assign pc_word        = pc_addr[3:1];
    assign unused_pc_bit0 = pc_addr[0];

    assign lookup_hit   = (state == ST_IDLE) && valid[pc_index] && (tags[pc_index] == pc_tag);
    assign inst_valid   = !rst && lookup_hit && !flush;
    assign inst         = inst_valid ? data[pc_index][pc_word] : 16'h0000;
    assign icache_stall = !rst && !inst_valid && !flush;
    assign start        = !rst && (state == ST_IDLE) && !flush && !lookup_hit;

    icache_fill_ctrl u_fill_ctrl (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_block    (pc_addr[15:4]),
        .mem_grant      (mem_grant),
        .mem_data_valid (mem_data_valid),
        .state          (state),
        .block          (block),
        .rc             (rc),
        .data_we        (data_we),
        .install        (install),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr)
    );

    // The line is invalidated at fill entry so a half-written block never hits.
    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (start)
            valid[pc_index] <= 1'b0;
        else if (install)
            valid[block[INDEX_BITS-1:0]] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (install)
            tags[block[INDEX_BITS-1:0]] <= block[11:INDEX_BITS];
        if (data_we)
            data[block[INDEX_BITS-1:0]][rc] <= mem_data;
    end

`ifdef ICACHE_PERF_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;
    logic [15:0] last_hit_addr;
    logic        last_hit;

    // Holding the PC on one hit address counts once, not once per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q         <= '0;
            miss_q        <= '0;
            last_hit_addr <= '0;
            last_hit      <= 1'b0;
        end else begin
            if (inst_valid && (!last_hit || pc_addr != last_hit_addr) && hit_q != 16'hFFFF)
                hit_q <= hit_q + 16'd1;
            if (start && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
            last_hit <= inst_valid;
            if (inst_valid)
                last_hit_addr <= pc_addr;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Self-checking bench for icache_fetch_unit: directed scenarios plus a random
// phase, compared every cycle against a line-level behavioural model.
module tb_icache_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_addr;
    logic        flush;
    logic [15:0] inst;
    logic        inst_valid;
    logic        icache_stall;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_grant;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    icache_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_addr        (pc_addr),
        .flush          (flush),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .icache_stall   (icache_stall),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .mem_grant      (mem_grant),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit lat_rand    = 1'b0;

    typedef struct {
        logic [15:0] addr;
        int          ready;
    } req_t;
    req_t        mq[$];
    logic [15:0] iss_q[$];

    // Model: per-line valid/tag; line contents are whatever memory holds.
    bit          m_valid [64];
    logic [5:0]  m_tag   [64];
    int          m_phase;      // 0 lookup, 1 fetching block, 2 installing
    logic [11:0] m_base;
    int          m_iss;
    int          m_ret;
    logic [15:0] m_hits;
    logic [15:0] m_misses;
    bit          m_last_hit;
    logic [15:0] m_last_pc;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        logic [31:0] p;
        p = a * 32'd40503;
        return p[15:0] ^ 16'h3C5A ^ {a[7:0], a[15:8]};
    endfunction

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    initial begin
        m_phase    = 0;
        m_base     = '0;
        m_iss      = 0;
        m_ret      = 0;
        m_hits     = '0;
        m_misses   = '0;
        m_last_hit = 1'b0;
        m_last_pc  = '0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
    end

    // Compare process: outputs are stable here, half a cycle after inputs change.
    always @(negedge clk) begin
        logic [15:0] e_inst, e_addr;
        logic        e_hit, e_iv, e_st, e_en;
        int          idx, fidx;
        idx    = int'(pc_addr[9:4]);
        e_hit  = !rst && m_phase == 0 && m_valid[idx] && m_tag[idx] == pc_addr[15:10];
        e_iv   = e_hit && !flush;
        e_inst = e_iv ? memfn({pc_addr[15:1], 1'b0}) : 16'h0000;
        e_st   = !rst && !e_iv && !flush;
        e_en   = !rst && m_phase == 1 && m_iss < 8;
        e_addr = e_en ? ({m_base, 4'b0000} + 16'(2 * m_iss)) : 16'h0000;
        chk("inst", inst, e_inst);
        chk("inst_valid", 16'(inst_valid), 16'(e_iv));
        chk("icache_stall", 16'(icache_stall), 16'(e_st));
        chk("mem_en", 16'(mem_en), 16'(e_en));
        chk("mem_addr", mem_addr, e_addr);
`ifdef ICACHE_PERF_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`else
        chk("hit_count", hit_count, 16'h0000);
        chk("miss_count", miss_count, 16'h0000);
`endif
        // Memory: accept granted reads, return them in order after a latency.
        if (mem_en && mem_grant)
            mq.push_back('{addr: mem_addr, ready: cyc + (lat_rand ? int'($urandom_range(6, 1)) : 4)});
        if (mem_data_valid && mq.size() > 0)
            void'(mq.pop_front());
        // Advance the model to the state after this clock edge.
        if (rst) begin
            m_phase    = 0;
            m_hits     = '0;
            m_misses   = '0;
            m_last_hit = 1'b0;
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (!flush && !e_hit) begin
                        m_phase      = 1;
                        m_base       = pc_addr[15:4];
                        m_iss        = 0;
                        m_ret        = 0;
                        m_valid[idx] = 1'b0;
                        if (m_misses != 16'hFFFF) m_misses++;
                    end
                    if (e_iv && (!m_last_hit || pc_addr != m_last_pc) && m_hits != 16'hFFFF)
                        m_hits++;
                end
                1: begin
                    if (e_en && mem_grant) m_iss++;
                    if (mem_data_valid) begin
                        m_ret++;
                        if (m_ret == 8) m_phase = 2;
                    end
                end
                default: begin
                    fidx          = int'(m_base[5:0]);
                    m_valid[fidx] = 1'b1;
                    m_tag[fidx]   = m_base[11:6];
                    m_phase       = 0;
                end
            endcase
            m_last_hit = e_iv;
            if (e_iv) m_last_pc = pc_addr;
        end
    end

    task automatic drive(input logic r, input logic [15:0] pc, input logic fl, input logic gr);
        @(posedge clk);
        #1;
        cyc++;
        rst       = r;
        pc_addr   = pc;
        flush     = fl;
        mem_grant = gr;
        if (mq.size() > 0 && mq[0].ready <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data       = memfn(mq[0].addr);
        end else begin
            mem_data_valid = 1'b0;
            mem_data       = 16'($urandom);
        end
        #2;
    endtask

    // Holds pc until a hit; collects issued addresses and counts stall cycles.
    task automatic run_until_valid(input logic [15:0] pc, input bit toggle_grant,
                                   input int maxc, output int n_stall);
        logic g;
        g       = 1'b1;
        n_stall = 0;
        iss_q.delete();
        for (int i = 0; i < maxc; i++) begin
            drive(1'b0, pc, 1'b0, g);
            if (mem_en && mem_grant) iss_q.push_back(mem_addr);
            if (inst_valid) return;
            if (icache_stall) n_stall++;
            if (toggle_grant) g = ~g;
        end
        miscompares++;
        $display("FAIL timeout waiting for hit on pc %h after %0d cycles", pc, maxc);
    endtask

    task automatic check_block_addrs(input string nm, input logic [15:0] base);
        chk({nm, "_count"}, 16'(iss_q.size()), 16'd8);
        for (int i = 0; i < iss_q.size(); i++)
            chk(nm, iss_q[i], base + 16'(2 * i));
    endtask

    task automatic drain_with_flush(input logic [15:0] pc);
        for (int k = 0; k < 40 && mq.size() > 0; k++)
            drive(1'b0, pc, 1'b1, 1'b1);
    endtask

    logic [15:0] pool [6] = '{16'h0000, 16'h0400, 16'h0120, 16'h8120, 16'hFFF0, 16'h0300};

    initial begin
        int          ns, n1, nret;
        logic [15:0] pc;
        logic        r;
        rst            = 1'b1;
        pc_addr        = 16'h0000;
        flush          = 1'b0;
        mem_grant      = 1'b1;
        mem_data_valid = 1'b0;
        mem_data       = 16'h0000;

        // Cold miss at 0x0000: 8 issues + latency 4 + 2 stall cycles.
        drive(1'b1, 16'h0000, 1'b0, 1'b1);
        drive(1'b1, 16'h0000, 1'b0, 1'b1);
        chk("reset_stall", 16'(icache_stall), 16'd0);
        chk("reset_mem_en", 16'(mem_en), 16'd0);
        run_until_valid(16'h0000, 1'b0, 40, ns);
        chk("miss_penalty", 16'(ns), 16'd14);
        check_block_addrs("a_fill_addr", 16'h0000);
        chk("a_inst", inst, memfn(16'h0000));
`ifdef ICACHE_PERF_EN
        chk("a_miss_count", miss_count, 16'd1);
`endif

        // Sequential hits through the freshly installed block.
        for (int w = 1; w < 8; w++) begin
            drive(1'b0, 16'(2 * w), 1'b0, 1'b1);
            chk("b_hit", 16'(inst_valid), 16'd1);
            chk("b_stall", 16'(icache_stall), 16'd0);
        end
`ifdef ICACHE_PERF_EN
        chk("b_hit_count", hit_count, 16'd8);
`endif

        // Index conflict: 0x0400 evicts line 0, then 0x0000 refetches it.
        run_until_valid(16'h0400, 1'b0, 60, ns);
        n1 = iss_q.size();
        run_until_valid(16'h0000, 1'b0, 60, ns);
        chk("c_issues", 16'(n1 + iss_q.size()), 16'd16);
        chk("c_inst", inst, memfn(16'h0000));

        // Alternating grant: no duplicated or skipped request.
        run_until_valid(16'h0200, 1'b1, 80, ns);
        check_block_addrs("d_fill_addr", 16'h0200);

        // Flush on fill cycle 3 with redirect to cached 0x0004.
        drive(1'b0, 16'h0120, 1'b0, 1'b1);
        drive(1'b0, 16'h0120, 1'b0, 1'b1);
        drive(1'b0, 16'h0120, 1'b0, 1'b1);
        drive(1'b0, 16'h0004, 1'b1, 1'b1);
        chk("e_flush_stall", 16'(icache_stall), 16'd0);
        chk("e_flush_valid", 16'(inst_valid), 16'd0);
        run_until_valid(16'h0004, 1'b0, 40, ns);
        chk("e_stall_after_flush", 16'(ns), 16'd10);
        drive(1'b0, 16'h0120, 1'b0, 1'b1);
        chk("e_line_120", 16'(inst_valid), 16'd1);

        // Reset after three words of a fill; the line must refill from scratch.
        nret = 0;
        for (int i = 0; i < 30 && nret < 3; i++) begin
            drive(1'b0, 16'h0300, 1'b0, 1'b1);
            if (mem_data_valid) nret++;
        end
        drive(1'b1, 16'h0300, 1'b0, 1'b1);
        chk("f_rst_mem_en", 16'(mem_en), 16'd0);
        drain_with_flush(16'h0300);
        drive(1'b0, 16'h0300, 1'b0, 1'b1);
        chk("f_miss_after_rst", 16'(icache_stall), 16'd1);
        run_until_valid(16'h0300, 1'b0, 40, ns);
        check_block_addrs("f_refill_addr", 16'h0300);

        // Top-of-memory block: addresses stay inside 0xFFF0..0xFFFE.
        run_until_valid(16'hFFFE, 1'b0, 40, ns);
        check_block_addrs("h_wrap_addr", 16'hFFF0);

        // Random traffic against the model.
        lat_rand = 1'b1;
        pc       = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 30)
                pc = pool[$urandom_range(5)] | 16'($urandom_range(15));
            r = ($urandom_range(999) < 4);
            drive(r, pc, $urandom_range(99) < 8, $urandom_range(99) < 75);
            if (r) drain_with_flush(pc);
        end

        drive(1'b0, pc, 1'b1, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
